// File: rtl/lut_sweep_pkg.sv
// ============================================================================
// Module      : lut_sweep_pkg
// Description : Shared types, widths and golden function for the LUT sweep checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lut_sweep_pkg;

    localparam int LUT_IN_W  = 5;
    localparam int LUT_OUT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bit 2 is a registered output on the device; once the vector has settled
    // it equals the combinational value of the held stimulus.
    function automatic logic [LUT_OUT_W-1:0] golden_comb(input logic [LUT_IN_W-1:0] stim);
        logic [LUT_OUT_W-1:0] o;
        o[0] = stim[0] | stim[1];
        o[1] = stim[2] | stim[3];
        o[2] = stim[4] | stim[0];
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lut_sweep_golden.sv
// ============================================================================
// Module      : lut_sweep_golden
// Description : Combinational reference model wrapping golden_comb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_sweep_golden
    import lut_sweep_pkg::*;
(
    input  logic [LUT_IN_W-1:0]  stim,
    output logic [LUT_OUT_W-1:0] expected
);

    assign expected = golden_comb(stim);

endmodule

`default_nettype wire

// File: rtl/lut_sweep_checker.sv
// ============================================================================
// Module      : lut_sweep_checker
// Description : Sweeps all input vectors into the LUT+FF design and checks the
//               responses. Optional macro LUT_SWEEP_STOP_ON_FAIL_EN ends the
//               sweep at the first mismatching vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_sweep_checker
    import lut_sweep_pkg::*;
#(
    parameter int IN_W          = LUT_IN_W,
    parameter int OUT_W         = LUT_OUT_W,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [IN_W-1:0]  first_fail
);

    localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    generate
        if (IN_W != LUT_IN_W) begin : g_bad_in_w
            $error("lut_sweep_checker: IN_W must be %0d", LUT_IN_W);
        end
        if (OUT_W != LUT_OUT_W) begin : g_bad_out_w
            $error("lut_sweep_checker: OUT_W must be %0d", LUT_OUT_W);
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("lut_sweep_checker: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IN_W-1:0]   r_stim;
    logic [CNT_W-1:0]  r_cnt;
    logic [ERR_W-1:0]  r_err_count;
    logic              r_fail_valid;
    logic [IN_W-1:0]   r_first_fail;
    logic              r_pass;
    logic [OUT_W-1:0]  w_expected;
    logic              w_mismatch;
    logic              w_last_vec;
    logic              w_stop;

    lut_sweep_golden u_golden (
        .stim     (r_stim),
        .expected (w_expected)
    );

    assign w_mismatch = (resp != w_expected);
    assign w_last_vec = (r_stim == {IN_W{1'b1}});

`ifdef LUT_SWEEP_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) w_state_nxt = SETTLE;
            end
            SETTLE: begin
                if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) w_state_nxt = CHECK;
            end
            CHECK: begin
                if (w_last_vec || w_stop) w_state_nxt = DONE;
                else                      w_state_nxt = SETTLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_stim       <= '0;
            r_cnt        <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_stim       <= '0;
                        r_cnt        <= '0;
                        r_err_count  <= '0;
                        r_fail_valid <= 1'b0;
                        r_first_fail <= '0;
                        r_pass       <= 1'b0;
                    end
                end
                SETTLE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_count != {ERR_W{1'b1}}) r_err_count <= r_err_count + ERR_W'(1);
                        if (!r_fail_valid) begin
                            r_fail_valid <= 1'b1;
                            r_first_fail <= r_stim;
                        end
                    end
                    // Stimulus is left on the failing/last vector when the sweep ends.
                    if (w_state_nxt == DONE) begin
                        r_pass <= !r_fail_valid && !w_mismatch;
                    end else begin
                        r_stim <= r_stim + IN_W'(1);
                        r_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stim       = r_stim;
    assign busy       = (r_state == SETTLE) || (r_state == CHECK);
    assign done       = (r_state == DONE);
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign fail_valid = r_fail_valid;
    assign first_fail = r_first_fail;

endmodule

`default_nettype wire

// File: tb/tb_lut_sweep_checker.sv
// ============================================================================
// Module      : tb_lut_sweep_checker
// Description : Directed bench: two checkers (default / ERR_W=4,SETTLE=3) against a
//               behavioural device model with selectable faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lut_sweep_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    int         mode = 0;   // 0 good, 1 o0 stuck 0, 2 o1 inverted, 3 o2 three stages late
    int         total = 0;
    int         bad = 0;

    logic [4:0] stim_a, stim_b, ff_a, ff_b;
    logic [2:0] resp_a, resp_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b;
    logic [7:0] err_a;
    logic [3:0] err_b;
    logic [2:0] dly_a = 3'b000, dly_b = 3'b000;

    always #5 clk = ~clk;

    lut_sweep_checker dut_a (
        .clk(clk), .rst(rst), .start(start), .stim(stim_a), .resp(resp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_valid(fv_a), .first_fail(ff_a)
    );

    lut_sweep_checker #(.ERR_W(4), .SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stim(stim_b), .resp(resp_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_valid(fv_b), .first_fail(ff_b)
    );

    // Device model: bit 2 of each chain is the FF output sampled 1..3 edges back.
    always @(posedge clk) begin
        dly_a <= {dly_a[1:0], stim_a[4] | stim_a[0]};
        dly_b <= {dly_b[1:0], stim_b[4] | stim_b[0]};
    end

    function automatic logic [2:0] model(input logic [4:0] s, input logic [2:0] d, input int m);
        logic [2:0] r;
        r[0] = s[0] | s[1];
        r[1] = s[2] | s[3];
        r[2] = (m == 3) ? d[2] : d[0];
        if (m == 1) r[0] = 1'b0;
        if (m == 2) r[1] = ~r[1];
        return r;
    endfunction

    assign resp_a = model(stim_a, dly_a, mode);
    assign resp_b = model(stim_b, dly_b, mode);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(output int ca, output int cb);
        ca = -1;
        cb = -1;
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        check("busy_a_after_start", 32'(busy_a), 32'd1);
        check("busy_b_after_start", 32'(busy_b), 32'd1);
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (done_a && ca < 0) ca = n;
            if (done_b && cb < 0) cb = n;
            if (ca >= 0 && cb >= 0) break;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    int ca, cb;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        check("rst_stim", 32'(stim_a), 32'd0);
        check("rst_err",  32'(err_a),  32'd0);
        check("rst_fv",   32'(fv_a),   32'd0);
        check("rst_ff",   32'(ff_a),   32'd0);

        // Good device
        mode = 0;
        run_sweep(ca, cb);
        check("good_cyc_a",  32'(ca), 32'd96);
        check("good_cyc_b",  32'(cb), 32'd128);
        check("good_pass_a", 32'(pass_a), 32'd1);
        check("good_pass_b", 32'(pass_b), 32'd1);
        check("good_err_a",  32'(err_a), 32'd0);
        check("good_fv_a",   32'(fv_a), 32'd0);
        check("good_stim_a", 32'(stim_a), 32'd31);
        check("good_done_a", 32'(done_a), 32'd1);

        // o[0] stuck at 0
        mode = 1;
        run_sweep(ca, cb);
        check("stuck_fv_a",   32'(fv_a), 32'd1);
        check("stuck_pass_a", 32'(pass_a), 32'd0);
        check("stuck_ff_a",   32'(ff_a), 32'd1);
        check("stuck_ff_b",   32'(ff_b), 32'd1);
`ifdef LUT_SWEEP_STOP_ON_FAIL_EN
        check("stuck_cyc_a",  32'(ca), 32'd6);
        check("stuck_cyc_b",  32'(cb), 32'd8);
        check("stuck_err_a",  32'(err_a), 32'd1);
        check("stuck_stim_a", 32'(stim_a), 32'd1);
`else
        check("stuck_cyc_a",  32'(ca), 32'd96);
        check("stuck_err_a",  32'(err_a), 32'd24);
        check("stuck_err_b",  32'(err_b), 32'd15);
        check("stuck_stim_a", 32'(stim_a), 32'd31);
`endif

        // o[1] inverted on every vector
        mode = 2;
        run_sweep(ca, cb);
        check("inv_ff_a",   32'(ff_a), 32'd0);
        check("inv_ff_b",   32'(ff_b), 32'd0);
        check("inv_pass_b", 32'(pass_b), 32'd0);
`ifdef LUT_SWEEP_STOP_ON_FAIL_EN
        check("inv_cyc_a",  32'(ca), 32'd3);
        check("inv_cyc_b",  32'(cb), 32'd4);
        check("inv_err_a",  32'(err_a), 32'd1);
        check("inv_err_b",  32'(err_b), 32'd1);
`else
        check("inv_err_a",  32'(err_a), 32'd32);
        check("inv_err_b",  32'(err_b), 32'd15);
`endif

        // o[2] three stages late: too slow for SETTLE_CYCLES=2, fine for 3
        mode = 3;
        run_sweep(ca, cb);
        check("dly_pass_a", 32'(pass_a), 32'd0);
        check("dly_fv_a",   32'(fv_a), 32'd1);
        check("dly_cyc_b",  32'(cb), 32'd128);
        check("dly_pass_b", 32'(pass_b), 32'd1);
        check("dly_err_b",  32'(err_b), 32'd0);
`ifdef LUT_SWEEP_STOP_ON_FAIL_EN
        check("dly_cyc_a",  32'(ca), 32'd6);
        check("dly_err_a",  32'(err_a), 32'd1);
        check("dly_ff_a",   32'(ff_a), 32'd1);
`else
        check("dly_cyc_a",  32'(ca), 32'd96);
        check("dly_err_a",  32'(err_a), 32'd16);
        check("dly_ff_a",   32'(ff_a), 32'd0);
`endif

        // start held through the sweep, then rst at cycle 40 together with start
        mode = 0;
        @(negedge clk) start = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("hold_stim_a", 32'(stim_a), 32'd13);
        check("hold_stim_b", 32'(stim_b), 32'd9);
        check("hold_busy_a", 32'(busy_a), 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy_a", 32'(busy_a), 32'd0);
        check("mid_rst_stim_a", 32'(stim_a), 32'd0);
        check("mid_rst_stim_b", 32'(stim_b), 32'd0);
        check("mid_rst_err_a",  32'(err_a), 32'd0);
        check("mid_rst_done_a", 32'(done_a), 32'd0);
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        @(posedge clk); #1;
        check("post_rst_idle_a", 32'(busy_a), 32'd0);
        check("post_rst_idle_b", 32'(busy_b), 32'd0);

        // Fresh sweep after reset
        run_sweep(ca, cb);
        check("final_cyc_a",  32'(ca), 32'd96);
        check("final_cyc_b",  32'(cb), 32'd128);
        check("final_pass_a", 32'(pass_a), 32'd1);
        check("final_err_a",  32'(err_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lut_sweep_checker.md
Name: lut_sweep_checker

Overview:
- Stimulus generator and response checker for the 5-input / 3-output LUT+FF feature design.
- Drives all 32 input vectors onto the design's input pads and samples its 3 output pads.
- Compares each sample against the golden function:
  - o[0] = i[0]|i[1]
  - o[1] = i[2]|i[3]
  - o[2] = registered (i[4]|i[0])
- Sits on the board/testbench side as the opposite end of the pad interface, and reports pass/fail plus an error count.

Parameters:
- IN_W, 5, stimulus width. Fixed by the golden function; any other value is an elaboration error.
- OUT_W, 3, response width. Fixed by the golden function; any other value is an elaboration error.
- SETTLE_CYCLES, 2, cycles each vector is held before the response is sampled. Must be >=1, which covers the FF latency; 0 is an elaboration error.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; honoured only in IDLE or DONE
- stim  output  IN_W  vector driven to the design's input pads
- resp  input  OUT_W  design's output pads
- busy  output  1  sweep in progress (SETTLE or CHECK)
- done  output  1  sweep finished; held until next start or rst
- pass  output  1  valid only while done; 1 iff err_count==0
- err_count  output  ERR_W  mismatching vectors, saturating at all-ones
- fail_valid  output  1  at least one mismatch recorded
- first_fail  output  IN_W  stim value of the first mismatch

Behaviour:
- All state synchronous to clk. rst (synchronous, active-high) overrides everything.
- Reset values:
  - state=IDLE
  - stim=0, busy=0, done=0, pass=0
  - err_count=0, fail_valid=0, first_fail=0
  - settle counter=0
- States: IDLE, SETTLE, CHECK, DONE. busy=1 exactly in SETTLE/CHECK; done=1 exactly in DONE.
- IDLE/DONE with start=1:
  - stim<=0; cnt<=0
  - err_count, fail_valid, first_fail, pass cleared
  - next state SETTLE
- SETTLE: cnt increments. When cnt==SETTLE_CYCLES-1, next state is CHECK.
- CHECK (one cycle): compare resp against golden(stim).
  - On mismatch: err_count increments, saturating. If fail_valid==0, set first_fail<=stim and fail_valid<=1.
  - If stim==2^IN_W-1: next state DONE, pass<=(no mismatch in whole sweep including this cycle).
  - Otherwise: stim<=stim+1, cnt<=0, next state SETTLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - With defaults, done rises 96 cycles after the cycle in which start is sampled.
  - stim stays stable throughout SETTLE and CHECK for a given vector.
- start while busy: ignored, with no effect on the sweep.
- DONE: outputs frozen; stim holds the last vector (31).
- rst mid-sweep: next cycle everything is at reset values; no partial results are retained.
- Simultaneous rst and start: rst wins.
- resp is sampled only in CHECK; X or glitches on resp in other cycles are don't-care.

Optional Feature:
- Macro: LUT_SWEEP_STOP_ON_FAIL_EN
- Defined:
  - The first mismatch in CHECK moves the FSM directly to DONE.
  - err_count=1, first_fail=the failing vector, pass=0.
  - stim holds the failing vector.
- Undefined: the full 32-vector sweep always completes, as specified above.

Decomposition:
- Package lut_sweep_pkg holds:
  - state enum (IDLE, SETTLE, CHECK, DONE)
  - IN_W/OUT_W constants
  - a function golden_comb(stim) returning the expected OUT_W vector
- Sub-module lut_sweep_golden: combinational wrapper of golden_comb, instantiated once so the bench can reuse it as a reference model.

Test Plan:
- Behavioural correct DUT model looped back, defaults, start pulse → busy=1 next cycle; done=1 and pass=1, err_count=0, fail_valid=0 exactly 96 cycles after start.
- resp[0] stuck at 0 → err_count=24, first_fail=5'd1, fail_valid=1, pass=0.
- resp[1] inverted with ERR_W=4 → err_count saturates at 15 (32 actual mismatches), first_fail=0.
- DUT model with o[2] delayed 3 cycles, SETTLE_CYCLES=2 → mismatches reported; same model with SETTLE_CYCLES=3 → pass=1.
- rst asserted for 1 cycle at cycle 40 of a sweep, plus start held high during busy → state IDLE and all outputs 0 after rst, start-while-busy ignored; new start gives a full 96-cycle pass.
- With LUT_SWEEP_STOP_ON_FAIL_EN, resp[0] stuck at 0 → done at the CHECK of vector 1 (cycle 6 after start), err_count=1, first_fail=1, stim=1.
